pe2ddr_sched: RTL
=================

# pe2ddr_sched

Sequences the PE-to-DDR writeback engine for one layer-output job. Accepts a job descriptor, then for each output group and transfer kind (data words, tail words) it issues a DDR write command, pulses the writeback engine's `start` with a matching configuration, and counts DDR beats until the transfer is done. Sits between the layer controller (job side) and the writeback engine plus the DDR write command channel.

## Interface
- `ADDR_W`, 32, DDR byte-address width
- `BEAT_BYTES`, 64, bytes per DDR data beat (DDR_W/8)
- `NUM_W`, 8, width of per-transfer beat counts
---
- `clk` in 1: clock
- `rst` in 1: reset; synchronous, active-high
- `job_valid` in 1 / `job_ready` out 1: job handshake
- `job_layer_type` in 4: bit0=1 per-group output, bit0=0 summed output
- `job_src` in 1: 0 = accumulation buffer, 1 = bias/tail buffer
- `job_ddr_base` in ADDR_W: first write byte address
- `job_data_num` in NUM_W: beats in the data transfer (0 = skip)
- `job_tail_num` in NUM_W: beats in the tail transfer (0 = skip)
- `job_grp_num` in 3: groups, 1..4 (0 treated as 1)
- `job_done` out 1: one-cycle pulse at job end
- `busy` out 1: state != IDLE
- `wb_start` out 1 / `wb_done` in 1: engine start pulse, completion pulse
- `wb_layer_type` out 4, `wb_trans_type` out 2, `wb_trans_num` out NUM_W, `wb_grp_sel` out 2: engine config
- `ddr2_valid` in 1, `ddr2_ready` in 1: monitored engine-to-DDR beat handshake
- `cmd_valid` out 1 / `cmd_ready` in 1: DDR write-command handshake
- `cmd_addr` out ADDR_W, `cmd_len` out NUM_W: command byte address, beat count
- `err_beat` out 1: sticky beat-overflow flag

## Operation
- States: IDLE, CMD, START, RUN, NEXT, DONE.
- IDLE: `job_ready`=1. On `job_valid&job_ready` latch all job fields; cur_addr←base, grp←0, phase←DATA; clear `err_beat`; go NEXT-select (see below).
- Phase select (on accept and in NEXT): iterate phase DATA then TAIL per group; skip a phase whose num=0; after TAIL advance grp. Group count = `job_grp_num` (0→1) only if `job_layer_type[0]`=1 and `job_src`=0; otherwise 1. No phase left → DONE, else CMD.
- CMD: `cmd_valid`=1, `cmd_addr`=cur_addr, `cmd_len`=num; hold stable until `cmd_ready`; then START.
- START: `wb_start`=1 for exactly one cycle; clear beat_cnt and done_seen; → RUN.
- Config: `wb_trans_type`={src, phase==TAIL}, `wb_trans_num`=num, `wb_grp_sel`=grp, `wb_layer_type`=latched; stable from CMD entry through RUN exit.
- Beat counting in START and RUN: beat = `ddr2_valid&ddr2_ready`. beat with beat_cnt==num sets `err_beat`, count saturates.
- RUN: `wb_done` sets done_seen. Exit to NEXT when done_seen (or `wb_done` this cycle) and beat_cnt (incl. this cycle's beat) == num; either order allowed.
- NEXT: cur_addr += num*BEAT_BYTES (mod 2^ADDR_W, wraps silently); phase select.
- DONE: `job_done`=1 one cycle; → IDLE.

## Timing
- Reset: state IDLE; `job_ready`=1, `busy`/`job_done`/`wb_start`/`cmd_valid`/`err_beat`=0; cmd_addr, cmd_len, wb_* = 0. Reset mid-job abandons it immediately, no `job_done`.
- Accept at cycle T → `cmd_valid` at T+1 (or `job_done` at T+1 if all phases skipped).
- Command accepted at C → `wb_start` at C+1, RUN from C+2.
- Completion condition met at R → NEXT at R+1 → next `cmd_valid` or `job_done` at R+2.
- Zero-length phases cost no cycles. `job_valid` ignored while busy.
- All outputs registered; `job_ready` = (state==IDLE).

## Test plan
- base=0x1000, src=0, layer_type=0, data=4, tail=2, grp=4 → cmd (0x1000,4) trans_type 00, then (0x1100,2) trans_type 01, grp_sel 0, one group only; `job_done` after 6 beats.
- Same with layer_type=1, grp=3, tail=0 → 3 cmds: 0x1000, 0x1100, 0x1200, len 4, grp_sel 0,1,2, trans_type 00.
- src=1, data=0, tail=0 → `job_done` at T+1, no `cmd_valid`/`wb_start`.
- `cmd_ready` held low 5 cycles → cmd_addr/len stable, no `wb_start` until accept; `wb_done` before final beat vs after → both exit RUN on the cycle both met.
- Engine sends 5 beats for num=4 → `err_beat`=1, held until next accept; base=0xFFFFFFC0, data=2 → second address wraps to 0x40.
- Reset asserted in RUN → next cycle IDLE, all outputs at reset values; new job proceeds normally.

Source files
------------

// File: rtl/pe2ddr_sched.sv
// pe2ddr_sched: sequences the PE-to-DDR writeback engine for one layer-output job.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   job_*                          - job descriptor handshake from the layer controller, job_done pulse
//   busy                           - scheduler not idle
//   wb_start/wb_done, wb_*         - writeback engine start/completion and per-transfer configuration
//   ddr2_valid/ddr2_ready          - monitored engine-to-DDR beat handshake
//   cmd_valid/cmd_ready, cmd_*     - DDR write command channel
//   err_beat                       - sticky flag: engine sent more beats than commanded
module pe2ddr_sched #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BEAT_BYTES = 64,
    parameter int unsigned NUM_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [3:0]        job_layer_type,
    input  logic              job_src,
    input  logic [ADDR_W-1:0] job_ddr_base,
    input  logic [NUM_W-1:0]  job_data_num,
    input  logic [NUM_W-1:0]  job_tail_num,
    input  logic [2:0]        job_grp_num,
    output logic              job_done,
    output logic              busy,
    output logic              wb_start,
    input  logic              wb_done,
    output logic [3:0]        wb_layer_type,
    output logic [1:0]        wb_trans_type,
    output logic [NUM_W-1:0]  wb_trans_num,
    output logic [1:0]        wb_grp_sel,
    input  logic              ddr2_valid,
    input  logic              ddr2_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [NUM_W-1:0]  cmd_len,
    output logic              err_beat
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_START, S_RUN, S_NEXT, S_DONE} state_t;

    state_t r_state, w_state_n;

    logic [3:0]        r_layer_type;
    logic              r_src;
    logic [NUM_W-1:0]  r_data_num, r_tail_num;
    logic [2:0]        r_gcnt, r_grp;
    logic              r_phase;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [NUM_W-1:0]  r_beat_cnt;
    logic              r_done_seen;

    logic              r_job_ready, r_job_done, r_busy, r_wb_start, r_cmd_valid, r_err_beat;
    logic [3:0]        r_wb_layer_type;
    logic [1:0]        r_wb_trans_type, r_wb_grp_sel;
    logic [NUM_W-1:0]  r_wb_trans_num, r_cmd_len;
    logic [ADDR_W-1:0] r_cmd_addr;

    logic              w_sel_src, w_sel_phase, w_sel_found;
    logic [3:0]        w_sel_lt;
    logic [NUM_W-1:0]  w_sel_data, w_sel_tail, w_sel_num;
    logic [2:0]        w_sel_gcnt, w_sel_grp, w_job_gcnt;

    logic [NUM_W-1:0]  w_num, w_beat_cnt_n;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_beat, w_beat_ovf, w_accept, w_load_cfg;

    assign w_num        = r_phase ? r_tail_num : r_data_num;
    assign w_addr_next  = r_cur_addr + (ADDR_W'(w_num) * ADDR_W'(BEAT_BYTES));
    assign w_beat       = ddr2_valid & ddr2_ready;
    assign w_beat_ovf   = w_beat && (r_beat_cnt == w_num);
    assign w_beat_cnt_n = (w_beat && !w_beat_ovf) ? r_beat_cnt + NUM_W'(1) : r_beat_cnt;
    assign w_load_cfg   = (w_state_n == S_CMD) && (r_state != S_CMD);

    // Next non-empty (group, phase): from (0, DATA) on accept, from just past the current phase in NEXT
    always_comb begin
        w_job_gcnt = 3'd1;
        if (job_layer_type[0] && !job_src) begin
            if (job_grp_num == 3'd0)      w_job_gcnt = 3'd1;
            else if (job_grp_num > 3'd4)  w_job_gcnt = 3'd4;
            else                          w_job_gcnt = job_grp_num;
        end
        if (r_state == S_IDLE) begin
            w_sel_src   = job_src;
            w_sel_lt    = job_layer_type;
            w_sel_data  = job_data_num;
            w_sel_tail  = job_tail_num;
            w_sel_gcnt  = w_job_gcnt;
            w_sel_grp   = 3'd0;
            w_sel_phase = 1'b0;
        end else begin
            w_sel_src   = r_src;
            w_sel_lt    = r_layer_type;
            w_sel_data  = r_data_num;
            w_sel_tail  = r_tail_num;
            w_sel_gcnt  = r_gcnt;
            w_sel_grp   = r_phase ? r_grp + 3'd1 : r_grp;
            w_sel_phase = ~r_phase;
        end
        if (w_sel_phase && (w_sel_tail == '0)) begin
            w_sel_grp   = w_sel_grp + 3'd1;
            w_sel_phase = 1'b0;
        end
        if (!w_sel_phase && (w_sel_data == '0)) begin
            w_sel_phase = 1'b1;
        end
        w_sel_num   = w_sel_phase ? w_sel_tail : w_sel_data;
        w_sel_found = (w_sel_grp < w_sel_gcnt) && (w_sel_num != '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_valid) begin
                    w_accept  = 1'b1;
                    w_state_n = w_sel_found ? S_CMD : S_DONE;
                end
            end
            S_CMD:   if (cmd_ready) w_state_n = S_START;
            S_START: w_state_n = S_RUN;
            S_RUN: begin
                // completion and final beat may arrive in either order or together
                if ((r_done_seen || wb_done) && (w_beat_cnt_n == w_num)) w_state_n = S_NEXT;
            end
            S_NEXT:  w_state_n = w_sel_found ? S_CMD : S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Job fields, transfer configuration and beat tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer_type    <= '0;
            r_src           <= 1'b0;
            r_data_num      <= '0;
            r_tail_num      <= '0;
            r_gcnt          <= 3'd1;
            r_grp           <= '0;
            r_phase         <= 1'b0;
            r_cur_addr      <= '0;
            r_beat_cnt      <= '0;
            r_done_seen     <= 1'b0;
            r_err_beat      <= 1'b0;
            r_cmd_addr      <= '0;
            r_cmd_len       <= '0;
            r_wb_layer_type <= '0;
            r_wb_trans_type <= '0;
            r_wb_trans_num  <= '0;
            r_wb_grp_sel    <= '0;
        end else begin
            if (w_accept) begin
                r_layer_type <= job_layer_type;
                r_src        <= job_src;
                r_data_num   <= job_data_num;
                r_tail_num   <= job_tail_num;
                r_gcnt       <= w_job_gcnt;
                r_cur_addr   <= job_ddr_base;
                r_err_beat   <= 1'b0;
            end
            if (r_state == S_NEXT) r_cur_addr <= w_addr_next;
            if (w_load_cfg) begin
                r_grp           <= w_sel_grp;
                r_phase         <= w_sel_phase;
                r_cmd_addr      <= (r_state == S_IDLE) ? job_ddr_base : w_addr_next;
                r_cmd_len       <= w_sel_num;
                r_wb_layer_type <= w_sel_lt;
                r_wb_trans_type <= {w_sel_src, w_sel_phase};
                r_wb_trans_num  <= w_sel_num;
                r_wb_grp_sel    <= w_sel_grp[1:0];
            end
            if (r_state == S_START) begin
                r_beat_cnt  <= w_beat ? NUM_W'(1) : '0;
                r_done_seen <= 1'b0;
            end
            if (r_state == S_RUN) begin
                r_beat_cnt <= w_beat_cnt_n;
                if (wb_done)    r_done_seen <= 1'b1;
                if (w_beat_ovf) r_err_beat  <= 1'b1;
            end
        end
    end

    // State-derived outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_job_done  <= 1'b0;
            r_wb_start  <= 1'b0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_job_ready <= (w_state_n == S_IDLE);
            r_busy      <= (w_state_n != S_IDLE);
            r_job_done  <= (w_state_n == S_DONE);
            r_wb_start  <= (w_state_n == S_START);
            r_cmd_valid <= (w_state_n == S_CMD);
        end
    end

    assign job_ready     = r_job_ready;
    assign busy          = r_busy;
    assign job_done      = r_job_done;
    assign wb_start      = r_wb_start;
    assign cmd_valid     = r_cmd_valid;
    assign err_beat      = r_err_beat;
    assign cmd_addr      = r_cmd_addr;
    assign cmd_len       = r_cmd_len;
    assign wb_layer_type = r_wb_layer_type;
    assign wb_trans_type = r_wb_trans_type;
    assign wb_trans_num  = r_wb_trans_num;
    assign wb_grp_sel    = r_wb_grp_sel;

endmodule
